// File: rtl/bist_mem_arbiter.sv
// bist_mem_arbiter: single-port memory arbiter between CPU and BIST engine.
// Hands the port to BIST on a bist_req edge, runs a watchdog, latches result.
//
// Ports:
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_cpu_req/we/adr/wdata     CPU access request
//   o_cpu_ready, o_cpu_rdata   CPU grant (combinational), read data
//   i_bist_req                 run request (rising edge arms one run)
//   o_bist_start               one-cycle start pulse to the engine
//   i_bist_done, i_bist_status engine finished / mismatch flag
//   i_bist_we/adr/wdata        engine memory access
//   o_bist_rdata               engine read data
//   o_mem_we/adr/wdata         to memory
//   i_mem_rdata                from memory
//   o_busy                     BIST owns memory
//   o_result_valid             one-cycle pulse at end of run
//   o_result_pass, o_timeout   sticky result of the last run

module bist_mem_arbiter #(
    parameter int ADR_SIZE  = 4,
    parameter int DATA_SIZE = 8,
    parameter int TIMEOUT_W = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cpu_req,
    input  logic                 i_cpu_we,
    input  logic [ADR_SIZE-1:0]  i_cpu_adr,
    input  logic [DATA_SIZE-1:0] i_cpu_wdata,
    output logic                 o_cpu_ready,
    output logic [DATA_SIZE-1:0] o_cpu_rdata,
    input  logic                 i_bist_req,
    output logic                 o_bist_start,
    input  logic                 i_bist_done,
    input  logic                 i_bist_status,
    input  logic                 i_bist_we,
    input  logic [ADR_SIZE-1:0]  i_bist_adr,
    input  logic [DATA_SIZE-1:0] i_bist_wdata,
    output logic [DATA_SIZE-1:0] o_bist_rdata,
    output logic                 o_mem_we,
    output logic [ADR_SIZE-1:0]  o_mem_adr,
    output logic [DATA_SIZE-1:0] o_mem_wdata,
    input  logic [DATA_SIZE-1:0] i_mem_rdata,
    output logic                 o_busy,
    output logic                 o_result_valid,
    output logic                 o_result_pass,
    output logic                 o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_ONE = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

    state_t               r_state;
    state_t               w_next;
    logic                 r_req_q;
    logic                 r_pending;
    logic                 w_rise;
    logic                 w_go;
    logic [TIMEOUT_W-1:0] r_wd;
    logic [TIMEOUT_W-1:0] w_wd_inc;
    logic                 w_wd_hit;
    logic                 r_pass;
    logic                 r_timeout;

    assign w_rise   = i_bist_req & ~r_req_q;
    assign w_go     = r_pending | w_rise;
    assign w_wd_inc = r_wd + WD_ONE;
    // Fires on the RUN cycle whose increment makes the count all-ones.
    assign w_wd_hit = (w_wd_inc == WD_MAX);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_next = S_START;
                end
            end
            S_START: w_next = S_RUN;
            S_RUN: begin
                if (i_bist_done || w_wd_hit) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request edge, watchdog and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req_q   <= 1'b0;
            r_pending <= 1'b0;
            r_wd      <= '0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_req_q <= i_bist_req;
            // Edges outside IDLE are dropped, not queued.
            if (w_next == S_START) begin
                r_pending <= 1'b0;
            end else if (w_rise && r_state == S_IDLE) begin
                r_pending <= 1'b1;
            end
            if (r_state == S_START) begin
                r_wd <= '0;
            end else if (r_state == S_RUN) begin
                r_wd <= w_wd_inc;
            end
            // Engine completion wins over a coincident watchdog hit.
            if (r_state == S_RUN) begin
                if (i_bist_done) begin
                    r_pass    <= ~i_bist_status;
                    r_timeout <= 1'b0;
                end else if (w_wd_hit) begin
                    r_pass    <= 1'b0;
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    // Output logic: memory mux follows the state register directly.
    always_comb begin
        o_cpu_ready    = 1'b0;
        o_bist_start   = 1'b0;
        o_busy         = 1'b0;
        o_result_valid = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_adr      = i_bist_adr;
        o_mem_wdata    = i_bist_wdata;
        unique case (r_state)
            S_IDLE: begin
                o_cpu_ready = i_cpu_req;
                o_mem_we    = i_cpu_we & i_cpu_req;
                o_mem_adr   = i_cpu_adr;
                o_mem_wdata = i_cpu_wdata;
            end
            S_START: begin
                o_bist_start = 1'b1;
                o_busy       = 1'b1;
                o_mem_we     = i_bist_we;
            end
            S_RUN: begin
                o_busy   = 1'b1;
                o_mem_we = i_bist_we;
            end
            S_DONE: begin
                o_result_valid = 1'b1;
            end
            default: begin
                o_mem_we = 1'b0;
            end
        endcase
    end

    assign o_cpu_rdata   = i_mem_rdata;
    assign o_bist_rdata  = i_mem_rdata;
    assign o_result_pass = r_pass;
    assign o_timeout     = r_timeout;

endmodule
